// File: rtl/operand2_shift_unit.sv
`default_nettype none
// ============================================================================
// operand2_shift_unit : multi-cycle ARM operand-2 shifter / sign-extender,
// STEP bits per cycle. Optional STATUS_FLAGS_EN adds flag_n / flag_z outputs.
// Revision 1.0
// ============================================================================
module operand2_shift_unit #(
  parameter  int DATA_W = 32,
  parameter  int STEP   = 1,
  localparam int AMT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        mode,
  input  logic [DATA_W-1:0] src,
  input  logic [AMT_W-1:0]  amt,
  input  logic              carry_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              carry_out
`ifdef STATUS_FLAGS_EN
  ,
  output logic              flag_n,
  output logic              flag_z
`endif
);

  localparam logic [2:0] c_LSL  = 3'd0;
  localparam logic [2:0] c_LSR  = 3'd1;
  localparam logic [2:0] c_ASR  = 3'd2;
  localparam logic [2:0] c_ROR  = 3'd3;
  localparam logic [2:0] c_RRX  = 3'd4;
  localparam logic [2:0] c_SEXT = 3'd5;

  localparam logic [AMT_W-1:0] c_W    = AMT_W'(DATA_W);
  localparam logic [AMT_W-1:0] c_W1   = AMT_W'(DATA_W + 1);
  localparam logic [AMT_W-1:0] c_STEP = AMT_W'(STEP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q;
  logic [2:0]        mode_q;
  logic [AMT_W-1:0]  rem_q;
  logic [DATA_W-1:0] data_q;
  logic              carry_q;
  logic              in_ready_q;
  logic              out_valid_q;

  logic [AMT_W-1:0]  rem_d;
  logic [DATA_W-1:0] data_d;
  logic              carry_d;

  logic [AMT_W-1:0]         w_rem_init;
  logic [DATA_W-1:0]        w_data_init;
  logic                     w_carry_init;
  logic [AMT_W-1:0]         w_sext_sh;
  logic signed [DATA_W-1:0] w_sext_tmp;
  logic [DATA_W-1:0]        w_sext;

  // Sign extension of the low amt bits: move the field to the top, then arithmetic shift back.
  assign w_sext_sh  = c_W - amt;
  assign w_sext_tmp = src << w_sext_sh;
  assign w_sext     = (amt == '0 || amt > c_W) ? '0 : $unsigned(w_sext_tmp >>> w_sext_sh);

  always_comb begin
    w_rem_init   = '0;
    w_data_init  = src;
    w_carry_init = carry_in;
    case (mode)
      c_LSL, c_LSR: w_rem_init = (amt > c_W1) ? c_W1 : amt;
      c_ASR:        w_rem_init = (amt > c_W) ? c_W : amt;
      c_ROR: begin
        w_rem_init = {1'b0, amt[AMT_W-2:0]};
        if (amt != '0 && amt[AMT_W-2:0] == '0) w_carry_init = src[DATA_W-1];
      end
      c_RRX: begin
        w_data_init  = {carry_in, src[DATA_W-1:1]};
        w_carry_init = src[0];
      end
      c_SEXT:  w_data_init = w_sext;
      default: ;
    endcase
  end

  // One SHIFT cycle applies min(STEP, rem_q) single-bit steps; carry tracks the last bit out.
  always_comb begin
    data_d  = data_q;
    carry_d = carry_q;
    for (int i = 0; i < STEP; i++) begin
      if (AMT_W'(i) < rem_q) begin
        case (mode_q)
          c_LSL: begin
            carry_d = data_d[DATA_W-1];
            data_d  = {data_d[DATA_W-2:0], 1'b0};
          end
          c_LSR: begin
            carry_d = data_d[0];
            data_d  = {1'b0, data_d[DATA_W-1:1]};
          end
          c_ASR: begin
            carry_d = data_d[0];
            data_d  = {data_d[DATA_W-1], data_d[DATA_W-1:1]};
          end
          default: begin
            carry_d = data_d[0];
            data_d  = {data_d[0], data_d[DATA_W-1:1]};
          end
        endcase
      end
    end
    rem_d = (rem_q > c_STEP) ? (rem_q - c_STEP) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mode_q      <= '0;
      rem_q       <= '0;
      data_q      <= '0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            mode_q     <= mode;
            rem_q      <= w_rem_init;
            data_q     <= w_data_init;
            carry_q    <= w_carry_init;
            in_ready_q <= 1'b0;
            if (w_rem_init == '0) begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          data_q  <= data_d;
          carry_q <= carry_d;
          rem_q   <= rem_d;
          if (rem_d == '0) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = data_q;
  assign carry_out = carry_q;

`ifdef STATUS_FLAGS_EN
  logic              flag_n_q;
  logic              flag_z_q;
  logic              w_load_done;
  logic [DATA_W-1:0] w_done_val;

  assign w_load_done = (state_q == S_IDLE)  ? (in_valid && in_ready_q && w_rem_init == '0) :
                       (state_q == S_SHIFT) ? (rem_d == '0) : 1'b0;
  assign w_done_val  = (state_q == S_IDLE) ? w_data_init : data_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flag_n_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else if (w_load_done) begin
      flag_n_q <= w_done_val[DATA_W-1];
      flag_z_q <= (w_done_val == '0);
    end
  end

  assign flag_n = flag_n_q;
  assign flag_z = flag_z_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_operand2_shift_unit.sv
`default_nettype none
// tb_operand2_shift_unit : STEP=1 and STEP=4 instances checked every cycle against a behavioural model.
module tb_operand2_shift_unit;
  localparam int W  = 32;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic          carry_in = 1'b0;
  logic [2:0]    mode = '0;
  logic [W-1:0]  src = '0;
  logic [AW-1:0] amt = '0;

  logic          ir [2];
  logic          ov [2];
  logic          co [2];
  logic [W-1:0]  res [2];
`ifdef STATUS_FLAGS_EN
  logic          fn [2];
  logic          fz [2];
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  operand2_shift_unit #(.DATA_W(W), .STEP(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .mode(mode), .src(src),
    .amt(amt), .carry_in(carry_in), .out_valid(ov[0]), .out_ready(out_ready),
    .result(res[0]), .carry_out(co[0])
`ifdef STATUS_FLAGS_EN
    , .flag_n(fn[0]), .flag_z(fz[0])
`endif
  );

  operand2_shift_unit #(.DATA_W(W), .STEP(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .mode(mode), .src(src),
    .amt(amt), .carry_in(carry_in), .out_valid(ov[1]), .out_ready(out_ready),
    .result(res[1]), .carry_out(co[1])
`ifdef STATUS_FLAGS_EN
    , .flag_n(fn[1]), .flag_z(fz[1])
`endif
  );

  task automatic chk(input bit ok, input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: result/carry from ARM shifter rules, latency from the remaining-count rule.
  task automatic model(input logic [2:0] m, input logic [W-1:0] s, input logic [AW-1:0] a,
                       input logic ci, input int step,
                       output logic [W-1:0] r, output logic c, output int lat);
    int n, rcnt, ra;
    logic [W-1:0] mask;
    n = int'(a); r = s; c = ci; rcnt = 0;
    case (m)
      3'd0: begin
        rcnt = (n > W + 1) ? W + 1 : n;
        if (n == 0) ;
        else if (n < W) begin r = s << n; c = s[W-n]; end
        else if (n == W) begin r = '0; c = s[0]; end
        else begin r = '0; c = 1'b0; end
      end
      3'd1: begin
        rcnt = (n > W + 1) ? W + 1 : n;
        if (n == 0) ;
        else if (n < W) begin r = s >> n; c = s[n-1]; end
        else if (n == W) begin r = '0; c = s[W-1]; end
        else begin r = '0; c = 1'b0; end
      end
      3'd2: begin
        rcnt = (n > W) ? W : n;
        if (n == 0) ;
        else if (n < W) begin r = $signed(s) >>> n; c = s[n-1]; end
        else begin r = {W{s[W-1]}}; c = s[W-1]; end
      end
      3'd3: begin
        ra = n % W; rcnt = ra;
        if (n == 0) ;
        else if (ra == 0) c = s[W-1];
        else begin r = (s >> ra) | (s << (W - ra)); c = s[ra-1]; end
      end
      3'd4: begin r = {ci, s[W-1:1]}; c = s[0]; end
      3'd5: begin
        if (n >= 1 && n <= W) begin
          mask = (n == W) ? '1 : ((32'h1 << n) - 32'h1);
          r = s & mask;
          if (s[n-1]) r = r | ~mask;
        end else r = '0;
      end
      default: ;
    endcase
    lat = 1 + (rcnt + step - 1) / step;
  endtask

  bit           pend [2];
  int           cyc [2];
  int           lat_e [2];
  logic [W-1:0] rexp [2];
  logic         cexp [2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        pend[k] = 1'b0;
      end else begin
        chk(!(ir[k] && ov[k]), "ready_valid_overlap", {31'b0, ov[k]}, 32'h0);
        if (pend[k]) begin
          cyc[k]++;
          if (cyc[k] < lat_e[k]) begin
            chk(ov[k] == 1'b0, "early_valid", {31'b0, ov[k]}, 32'h0);
          end else begin
            chk(ov[k] == 1'b1, "valid_latency", {31'b0, ov[k]}, 32'h1);
            chk(res[k] == rexp[k], "result", res[k], rexp[k]);
            chk(co[k] == cexp[k], "carry_out", {31'b0, co[k]}, {31'b0, cexp[k]});
`ifdef STATUS_FLAGS_EN
            chk(fn[k] == rexp[k][W-1], "flag_n", {31'b0, fn[k]}, {31'b0, rexp[k][W-1]});
            chk(fz[k] == (rexp[k] == '0), "flag_z", {31'b0, fz[k]}, {31'b0, (rexp[k] == '0)});
`endif
            if (ov[k] && out_ready) pend[k] = 1'b0;
            else if (cyc[k] > lat_e[k] + 20) begin
              chk(1'b0, "result_timeout", cyc[k], lat_e[k]);
              pend[k] = 1'b0;
            end
          end
        end else begin
          chk(ov[k] == 1'b0, "spurious_valid", {31'b0, ov[k]}, 32'h0);
          if (in_valid && ir[k]) begin
            model(mode, src, amt, carry_in, (k == 0) ? 1 : 4, rexp[k], cexp[k], lat_e[k]);
            pend[k] = 1'b1;
            cyc[k]  = 0;
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (!(ir[0] && ir[1]) && t < 200) begin @(posedge clk); #1; t++; end
    if (t >= 200) chk(1'b0, "idle_timeout", t, 200);
  endtask

  task automatic issue(input logic [2:0] m, input logic [W-1:0] s, input logic [AW-1:0] a, input logic ci);
    wait_idle();
    mode = m; src = s; amt = a; carry_in = ci; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while ((pend[0] || pend[1]) && t < 200) begin @(posedge clk); #1; t++; end
    if (t >= 200) chk(1'b0, "done_timeout", t, 200);
  endtask

  task automatic op(input logic [2:0] m, input logic [W-1:0] s, input logic [AW-1:0] a, input logic ci);
    issue(m, s, a, ci);
    wait_done();
  endtask

  task automatic pin(input logic [2:0] m, input logic [W-1:0] s, input logic [AW-1:0] a, input logic ci,
                     input int step, input logic [W-1:0] er, input logic ec, input int el);
    logic [W-1:0] r;
    logic         c;
    int           l;
    model(m, s, a, ci, step, r, c, l);
    chk(r == er, "model_result", r, er);
    chk(c == ec, "model_carry", {31'b0, c}, {31'b0, ec});
    chk(l == el, "model_latency", l, el);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pick;
    logic [AW-1:0] a;

    pin(3'd0, 32'h8000_0001, 6'd1,  1'b0, 1, 32'h0000_0002, 1'b1, 2);
    pin(3'd2, 32'h8000_0000, 6'd40, 1'b0, 1, 32'hFFFF_FFFF, 1'b1, 33);
    pin(3'd1, 32'h8000_0000, 6'd32, 1'b0, 1, 32'h0000_0000, 1'b1, 33);
    pin(3'd1, 32'h8000_0000, 6'd33, 1'b1, 1, 32'h0000_0000, 1'b0, 34);
    pin(3'd3, 32'h0000_00FF, 6'd4,  1'b0, 4, 32'hF000_000F, 1'b1, 2);
    pin(3'd3, 32'h0000_00FF, 6'd0,  1'b1, 4, 32'h0000_00FF, 1'b1, 1);
    pin(3'd4, 32'h0000_0003, 6'd0,  1'b1, 1, 32'h8000_0001, 1'b1, 1);
    pin(3'd5, 32'h0080_0000, 6'd24, 1'b0, 1, 32'hFF80_0000, 1'b0, 1);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      chk(ir[k] == 1'b1, "reset_in_ready", {31'b0, ir[k]}, 32'h1);
      chk(ov[k] == 1'b0, "reset_out_valid", {31'b0, ov[k]}, 32'h0);
      chk(res[k] == '0, "reset_result", res[k], 32'h0);
      chk(co[k] == 1'b0, "reset_carry", {31'b0, co[k]}, 32'h0);
    end

    op(3'd0, 32'h8000_0001, 6'd1,  1'b0);
    op(3'd2, 32'h8000_0000, 6'd40, 1'b0);
    op(3'd1, 32'h8000_0000, 6'd32, 1'b0);
    op(3'd1, 32'h8000_0000, 6'd33, 1'b1);
    op(3'd0, 32'h0000_0001, 6'd32, 1'b0);
    op(3'd0, 32'h0000_0001, 6'd33, 1'b1);
    op(3'd2, 32'h7FFF_FFFF, 6'd31, 1'b0);
    op(3'd3, 32'h0000_00FF, 6'd4,  1'b0);
    op(3'd3, 32'h0000_00FF, 6'd0,  1'b1);
    op(3'd3, 32'h8000_0001, 6'd32, 1'b0);
    op(3'd4, 32'h0000_0003, 6'd0,  1'b1);
    op(3'd5, 32'h0080_0000, 6'd24, 1'b1);
    op(3'd5, 32'h1234_5678, 6'd0,  1'b0);
    op(3'd5, 32'h1234_5678, 6'd40, 1'b0);
    op(3'd7, 32'hCAFE_F00D, 6'd9,  1'b1);

    // Backpressure: results must hold and a new request must be ignored.
    out_ready = 1'b0;
    issue(3'd0, 32'h0000_00F0, 6'd3, 1'b0);
    begin
      int t = 0;
      while (!(ov[0] && ov[1]) && t < 100) begin @(posedge clk); #1; t++; end
      if (t >= 100) chk(1'b0, "bp_valid_timeout", t, 100);
    end
    mode = 3'd1; src = 32'hFFFF_FFFF; amt = 6'd5; in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) chk(ir[k] == 1'b0, "bp_in_ready", {31'b0, ir[k]}, 32'h0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_done();

    // Reset during SHIFT aborts the operation.
    issue(3'd0, 32'h1234_5678, 6'd20, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      chk(ir[k] == 1'b1, "abort_in_ready", {31'b0, ir[k]}, 32'h1);
      chk(ov[k] == 1'b0, "abort_out_valid", {31'b0, ov[k]}, 32'h0);
      chk(res[k] == '0, "abort_result", res[k], 32'h0);
    end
    repeat (30) begin @(posedge clk); #1; end

    for (int i = 0; i < 250; i++) begin
      pick = $urandom_range(0, 3);
      case (pick)
        0: a = AW'($urandom_range(0, 63));
        1: begin
          case ($urandom_range(0, 4))
            0: a = 6'd0;
            1: a = 6'd1;
            2: a = 6'd31;
            3: a = 6'd32;
            default: a = 6'd33;
          endcase
        end
        default: a = AW'($urandom_range(0, 40));
      endcase
      op(3'($urandom_range(0, 7)), $urandom, a, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
